// File: rtl/n100_icb_stall_gen.sv
// Multi-channel ICB command stall injector: per-channel Galois LFSR or periodic/burst
// back-pressure with a hard cap on consecutive stalled-valid cycles. Optional
// per-channel statistics counters are built when N100_STALL_GEN_STATS_EN is defined.
module n100_icb_stall_gen #(
  parameter int                CH_NUM = 3,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int                RUN_W  = 4,
  parameter int                CNT_W  = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [CH_NUM-1:0]       cfg_en,
  input  logic [1:0]              cfg_mode,
  input  logic [7:0]              cfg_density,
  input  logic [RUN_W-1:0]        cfg_max_run,
  input  logic [7:0]              cfg_period,
  input  logic [CH_NUM-1:0]       icb_cmd_valid,
  output logic [CH_NUM-1:0]       stall_o,
  output logic [CH_NUM-1:0]       starve_o,
  output logic [CH_NUM*CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_RANDOM   = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_BURST    = 2'd3
  } mode_e;

  // x^16+x^14+x^13+x^11+1 for the 16-bit build; other widths fall back to a two-tap polynomial
  localparam logic [LFSR_W-1:0] TAPS = (LFSR_W == 16) ? LFSR_W'(16'hB400)
                                                       : (LFSR_W'(3) << (LFSR_W - 2));

  logic [7:0] r_frm;
  logic       w_frm_req;
  logic       w_max_zero;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_frm <= '0;
    end else if (r_frm >= cfg_period) begin
      r_frm <= '0;
    end else begin
      r_frm <= r_frm + 8'd1;
    end
  end

  always_comb begin
    w_frm_req  = 32'(r_frm) < 32'(cfg_max_run);
    w_max_zero = (cfg_max_run == '0);
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    localparam logic [15:0]       MIX     = 16'(i * 32'h9E37);
    localparam logic [LFSR_W-1:0] RAW     = SEED ^ LFSR_W'(MIX);
    localparam logic [LFSR_W-1:0] CH_SEED = (RAW == '0) ? LFSR_W'(1) : RAW;

    logic [LFSR_W-1:0] r_lfsr;
    logic [RUN_W-1:0]  r_run;
    logic              r_stall;
    logic              r_starve;
    logic              w_req;
    logic              w_arm;
    logic              w_cap;
    logic [RUN_W-1:0]  w_run_inc;

    // The cap counts the current stalled-valid cycle, so exactly cfg_max_run stalls pass before release
    always_comb begin
      w_req = 1'b0;
      case (mode_e'(cfg_mode))
        MODE_OFF:      w_req = 1'b0;
        MODE_RANDOM:   w_req = (r_lfsr[7:0] < cfg_density);
        MODE_PERIODIC: w_req = w_frm_req;
        MODE_BURST:    w_req = 1'b1;
        default:       w_req = 1'b0;
      endcase
      w_run_inc = r_run + RUN_W'(r_stall & icb_cmd_valid[i]);
      w_cap     = (w_run_inc >= cfg_max_run);
      w_arm     = cfg_en[i] & w_req & ~w_max_zero;
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        r_lfsr   <= CH_SEED;
        r_run    <= '0;
        r_stall  <= 1'b0;
        r_starve <= 1'b0;
      end else begin
        r_lfsr   <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
        r_stall  <= w_arm & ~w_cap;
        r_starve <= w_arm & w_cap;
        if (!cfg_en[i] || !r_stall || w_cap) begin
          r_run <= '0;
        end else begin
          r_run <= w_run_inc;
        end
      end
    end

    assign stall_o[i]  = r_stall;
    assign starve_o[i] = r_starve;

`ifdef N100_STALL_GEN_STATS_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        r_cnt <= '0;
      end else if (r_stall && icb_cmd_valid[i] && !(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign stall_cnt_o[i*CNT_W +: CNT_W] = r_cnt;
`endif
  end

`ifndef N100_STALL_GEN_STATS_EN
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_n100_icb_stall_gen.sv
// Self-checking bench for n100_icb_stall_gen: directed scenarios plus randomized segments,
// each cycle compared against a C-style LFSR / stall-streak reference model.
module tb_n100_icb_stall_gen;
  localparam int CH = 3;
  localparam int RW = 4;
  localparam int CW = 32;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic [CH-1:0]    cfg_en;
  logic [1:0]       cfg_mode;
  logic [7:0]       cfg_density;
  logic [RW-1:0]    cfg_max_run;
  logic [7:0]       cfg_period;
  logic [CH-1:0]    icb_cmd_valid;
  logic [CH-1:0]    stall_o;
  logic [CH-1:0]    starve_o;
  logic [CH*CW-1:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  int              mLfsr[CH];
  int              mFrm;
  bit              mStall[CH];
  bit              mStarve[CH];
  int              mStreak[CH];
  longint unsigned mCnt[CH];
  int              runObs[CH];
  int              maxRunObs;

  always #5 sys_clk = ~sys_clk;

  n100_icb_stall_gen #(
    .CH_NUM(CH), .LFSR_W(16), .SEED(16'hACE1), .RUN_W(RW), .CNT_W(CW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .cfg_density(cfg_density), .cfg_max_run(cfg_max_run), .cfg_period(cfg_period),
    .icb_cmd_valid(icb_cmd_valid), .stall_o(stall_o), .starve_o(starve_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference Galois step, as in the C model: shift right, xor taps when the lsb falls out
  function automatic int nextLfsr(input int l);
    int n;
    n = l >> 1;
    if ((l & 1) != 0) n = n ^ 'hB400;
    return n;
  endfunction

  task automatic modelReset();
    for (int ch = 0; ch < CH; ch++) begin
      int s;
      s = 'hACE1 ^ ((ch * 'h9E37) & 'hFFFF);
      if (s == 0) s = 1;
      mLfsr[ch]   = s;
      mStall[ch]  = 1'b0;
      mStarve[ch] = 1'b0;
      mStreak[ch] = 0;
      mCnt[ch]    = 0;
    end
    mFrm = 0;
  endtask

  // Streak = stalled-valid cycles in the current stall run, including the cycle now ending
  task automatic modelStep();
    int maxRun;
    maxRun = int'(cfg_max_run);
    for (int ch = 0; ch < CH; ch++) begin
      int req;
      int s;
      bit want;
      bit limit;
      case (cfg_mode)
        2'd0:    req = 0;
        2'd1:    req = ((mLfsr[ch] & 'hFF) < int'(cfg_density)) ? 1 : 0;
        2'd2:    req = (mFrm < maxRun) ? 1 : 0;
        default: req = 1;
      endcase
      s     = mStall[ch] ? mStreak[ch] + int'(icb_cmd_valid[ch]) : 0;
      want  = cfg_en[ch] && (req != 0) && (maxRun != 0);
      limit = (s >= maxRun);
      mStreak[ch] = (cfg_en[ch] && mStall[ch] && !limit) ? s : 0;
      if (mStall[ch] && icb_cmd_valid[ch] && mCnt[ch] != 64'hFFFF_FFFF) mCnt[ch]++;
      mStall[ch]  = want && !limit;
      mStarve[ch] = want && limit;
      mLfsr[ch]   = nextLfsr(mLfsr[ch]);
    end
    mFrm = (mFrm >= int'(cfg_period)) ? 0 : mFrm + 1;
  endtask

  task automatic applyStimulus(input bit rst, input logic [CH-1:0] en, input int mode,
                               input int dens, input int maxr, input int per,
                               input logic [CH-1:0] valid);
    sys_rst       = rst;
    cfg_en        = en;
    cfg_mode      = 2'(mode);
    cfg_density   = 8'(dens);
    cfg_max_run   = RW'(maxr);
    cfg_period    = 8'(per);
    icb_cmd_valid = valid;
  endtask

  task automatic checkOutput();
    logic [CH-1:0] es;
    logic [CH-1:0] et;
    for (int ch = 0; ch < CH; ch++) begin
      es[ch] = mStall[ch];
      et[ch] = mStarve[ch];
    end
    checkVal("stall", 64'(stall_o), 64'(es));
    checkVal("starve", 64'(starve_o), 64'(et));
`ifdef N100_STALL_GEN_STATS_EN
    for (int ch = 0; ch < CH; ch++) begin
      checkVal("stall_cnt", 64'(stall_cnt_o[ch*CW +: CW]), 64'(mCnt[ch]));
    end
`else
    checkVal("stall_cnt_tied", 64'(stall_cnt_o != '0), 64'(0));
`endif
  endtask

  // One clock: monitor observed runs, advance the model, then sample just after the edge
  task automatic step();
    for (int ch = 0; ch < CH; ch++) begin
      if (stall_o[ch] === 1'b1 && icb_cmd_valid[ch]) runObs[ch]++;
      else if (stall_o[ch] !== 1'b1) runObs[ch] = 0;
      if (runObs[ch] > maxRunObs) maxRunObs = runObs[ch];
    end
    if (sys_rst) modelReset();
    else modelStep();
    @(posedge sys_clk);
    #1;
    checkOutput();
    @(negedge sys_clk);
  endtask

  initial begin
    logic          anyOut;
    logic          diff;
    int            cnt;
    logic [CH-1:0] v;
    bit            perPat[11];
    perPat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int ch = 0; ch < CH; ch++) runObs[ch] = 0;
    maxRunObs = 0;

    applyStimulus(1'b1, '0, 0, 0, 0, 0, '0);
    @(negedge sys_clk);
    step();
    step();
    checkVal("reset_stall", 64'(stall_o), 64'(0));
    checkVal("reset_starve", 64'(starve_o), 64'(0));

    // Density 0 must never request a stall
    applyStimulus(1'b0, '1, 1, 0, 4, 0, '1);
    anyOut = 1'b0;
    repeat (1000) begin
      step();
      anyOut = anyOut | (|stall_o) | (|starve_o);
    end
    checkVal("density0_quiet", 64'(anyOut), 64'(0));

    // Burst with cap 4: 1,1,1,1,0 repeating, starve in each release cycle
    applyStimulus(1'b1, '1, 3, 0, 4, 0, '1);
    step();
    applyStimulus(1'b0, '1, 3, 0, 4, 0, '1);
    for (int k = 1; k <= 50; k++) begin
      step();
      checkVal("burst_stall", 64'(stall_o), (k % 5 != 0) ? 64'h7 : 64'h0);
      checkVal("burst_starve", 64'(starve_o), (k % 5 == 0) ? 64'h7 : 64'h0);
    end
`ifdef N100_STALL_GEN_STATS_EN
    checkVal("burst_cnt50", 64'(stall_cnt_o[CW-1:0]), 64'd40);
`endif

    // All-ones cap: 15 stalls then a guaranteed release
    applyStimulus(1'b1, '1, 3, 0, 15, 0, '1);
    step();
    applyStimulus(1'b0, '1, 3, 0, 15, 0, '1);
    for (int k = 1; k <= 16; k++) begin
      step();
      checkVal("cap15_stall", 64'(stall_o), (k <= 15) ? 64'h7 : 64'h0);
    end
    checkVal("cap15_starve", 64'(starve_o), 64'h7);

    // Dense random stalls with valid toggling: no run may exceed 15 stalled-valid cycles
    applyStimulus(1'b1, '1, 1, 255, 15, 0, '0);
    step();
    maxRunObs = 0;
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'b0, '1, 1, 255, 15, 0, (k % 2 != 0) ? '1 : '0);
      step();
    end
    checkVal("max_run_le15", 64'(maxRunObs > 15), 64'(0));

    // Periodic: 3 of every 10, then shrink the frame while frm is 7
    applyStimulus(1'b1, '1, 2, 0, 3, 9, '1);
    step();
    cnt = 0;
    for (int k = 1; k <= 27; k++) begin
      applyStimulus(1'b0, '1, 2, 0, 3, 9, '1);
      step();
      if (k >= 11 && k <= 20) cnt += int'(stall_o[0]);
    end
    checkVal("periodic_3of10", 64'(cnt), 64'd3);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b0, '1, 2, 0, 3, 4, '1);
      step();
      checkVal("period_shrink", 64'(stall_o[0]), 64'(perPat[k]));
    end

    // Random run with an enable drop, then a reset pulse mid-run
    applyStimulus(1'b1, '1, 1, 128, 6, 0, '1);
    step();
    for (int k = 0; k < 60; k++) begin
      v = CH'($urandom_range(0, 7));
      applyStimulus(1'b0, (k == 30) ? 3'b101 : 3'b111, 1, 128, 6, 0, v);
      step();
      if (k == 30) checkVal("en_low_clears", 64'(stall_o[1]), 64'(0));
    end
    applyStimulus(1'b1, '1, 1, 128, 6, 0, '1);
    step();
    checkVal("rst_mid_run", 64'(stall_o), 64'(0));
    for (int k = 0; k < 40; k++) begin
      v = CH'($urandom_range(0, 7));
      applyStimulus(1'b0, '1, 1, 128, 6, 0, v);
      step();
    end

    // Equal configs on channels 0 and 1 must diverge through distinct seeds
    applyStimulus(1'b1, '1, 1, 128, 15, 0, '1);
    step();
    diff = 1'b0;
    repeat (32) begin
      applyStimulus(1'b0, '1, 1, 128, 15, 0, '1);
      step();
      diff = diff | (stall_o[0] ^ stall_o[1]);
    end
    checkVal("seeds_distinct", 64'(diff), 64'(1));

    // Randomized configuration segments
    for (int seg = 0; seg < 10; seg++) begin
      int mode, dens, maxr, per;
      logic [CH-1:0] en;
      mode = int'($urandom_range(0, 3));
      dens = int'($urandom_range(0, 255));
      maxr = int'($urandom_range(0, 15));
      per  = int'($urandom_range(0, 20));
      en   = CH'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(1'b1, en, mode, dens, maxr, per, '1);
        step();
      end
      for (int k = 0; k < 100; k++) begin
        v = CH'($urandom_range(0, 7));
        applyStimulus(1'b0, en, mode, dens, maxr, per, v);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/n100_icb_stall_gen.md
# n100_icb_stall_gen

Parametrised multi-channel stall injector for the ICB command paths of the n100 local memories and system fabric. It drives `stall_uop_cmd`-style back-pressure from a per-channel LFSR or a periodic pattern, with a hard cap on consecutive stall cycles so forward progress is guaranteed. It replaces the ad-hoc forcing of single random bits onto the ILM/DLM stall nets: one instance serves ILM, DLM and fabric channels and can be placed in the testbench or in a stress-enabled SoC build.

## Interface
Parameters:
- `CH_NUM`, 3, number of independent stall channels (1..8)
- `LFSR_W`, 16, LFSR width; fixed taps `0xB400` (x^16+x^14+x^13+x^11+1) when 16
- `SEED`, 16'hACE1, base seed; channel i is seeded with `SEED ^ (i*16'h9E37)`, and a zero result is replaced by 1
- `RUN_W`, 4, width of the stall-run cap
- `CNT_W`, 32, statistics counter width (used only with the statistics macro)

Ports:
- `sys_clk`  in  1  sole clock
- `sys_rst`  in  1  synchronous reset, active-high
- `cfg_en`  in  CH_NUM  per-channel enable
- `cfg_mode`  in  2  0 off, 1 random, 2 periodic, 3 burst
- `cfg_density`  in  8  random threshold; stall request when `lfsr[7:0] < cfg_density`
- `cfg_max_run`  in  RUN_W  maximum consecutive stalled-valid cycles; 0 disables stalling
- `cfg_period`  in  8  periodic frame length minus 1
- `icb_cmd_valid`  in  CH_NUM  command valid of each stalled channel
- `stall_o`  out  CH_NUM  registered stall per channel
- `starve_o`  out  CH_NUM  pulse: a cap-forced release occurred this cycle
- `stall_cnt_o`  out  CH_NUM*CNT_W  stalled-valid cycle count per channel (statistics macro only)

## Operation
- Per channel: LFSR (Galois, shifts every cycle regardless of mode), run counter `run[RUN_W-1:0]`, and frame counter `frm[7:0]`, which is shared by all channels.
- Request `req`: mode 0 gives 0. Mode 1 gives `lfsr[7:0] < cfg_density`. Mode 2 gives `frm < cfg_max_run`. Mode 3 gives 1.
- `frm` counts 0..`cfg_period` and then wraps to 0. If `cfg_period` is below `frm`, `frm` wraps on the next cycle.
- Cap: `cap_hit = (run == cfg_max_run)`. The next `stall_o = cfg_en & req & (cfg_max_run != 0) & ~cap_hit`.
- `run` increments when `stall_o & icb_cmd_valid`. It clears when `stall_o` is low, when `cap_hit` is true, or when `cfg_en` is low. It does not advance while valid is low, because a stall with no request does not starve anything.
- `starve_o` is registered: it is 1 in the cycle where `cap_hit` forces `stall_o` low while `req` is 1.
- Mode 3 therefore gives exactly `cfg_max_run` stalled-valid cycles followed by a 1-cycle release, repeating.

## Timing
- Reset values: `stall_o`=0, `starve_o`=0, `run`=0, `frm`=0, LFSR=channel seed, `stall_cnt_o`=0.
- `stall_o` has 1 cycle of latency from config, LFSR state and `run`. Config changes are sampled at the next `sys_clk` edge and affect `stall_o` one cycle later.
- Deasserting `cfg_en` clears `stall_o` and `run` at the next edge, with no partial runs retained.
- Reset asserted mid-run: all state is back at its reset value at the next edge, and the LFSR sequence restarts identically.
- When `cfg_max_run` is the all-ones value, the cap allows 15 consecutive stalls (RUN_W=4) and the release is still guaranteed.
- `icb_cmd_valid` and `stall_o` can be high together, which counts as a stalled cycle. The stall must never depend combinationally on `icb_cmd_valid`.

## Configuration
- `N100_STALL_GEN_STATS_EN` defined: `stall_cnt_o` is present. Each CNT_W-bit counter increments on `stall_o & icb_cmd_valid`, saturates at all-ones, clears on `sys_rst` only, and is unaffected by `cfg_en`.
- Not defined: no counters are built and `stall_cnt_o` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, mode 1, density 0, all channels enabled, valid=1 for 1000 cycles -> `stall_o` stays 0 and `starve_o` stays 0.
- Mode 3, `cfg_max_run`=4, valid=1 continuously -> `stall_o` repeats the pattern 1,1,1,1,0. `starve_o` pulses in each 0 cycle. With stats enabled, the count after 50 cycles is 40 (±4 for startup alignment, checked exactly against the model).
- Mode 1, density 8'hFF, `cfg_max_run`=15, valid toggling every other cycle -> no stall run exceeds 15 valid-high cycles, and the sequence matches the C reference LFSR for SEED 16'hACE1.
- Mode 2, `cfg_period`=9, `cfg_max_run`=3 -> stall is high for 3 of every 10 cycles. Changing the period to 4 while `frm`=7 -> wrap on the next cycle, then a 5-cycle frame.
- Mode 1 run active, `sys_rst` pulsed for 1 cycle -> `stall_o`=0 in the following cycle, and the LFSR output after reset is identical to the first run.
- Two channels with equal config -> `stall_o` differs between them within 32 cycles, confirming distinct per-channel seeds.
